// File: rtl/addsub_ex_stage_pkg.sv
// Shared definitions for the saturating add/subtract execute stage.
package addsub_ex_stage_pkg;

  localparam int          DATA_W  = 16;
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sub;
    logic              upd_flags;
  } s1_payload_t;

endpackage

// File: rtl/addsub_ex_stage_cla.sv
// 16-bit two-level carry-lookahead add/subtract with signed saturation.
module cla_16bit
  import addsub_ex_stage_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              ovfl_o
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] p;
  logic [DATA_W-1:0] raw;
  logic [3:0]        grp_g;
  logic [3:0]        grp_p;
  logic [DATA_W:0]   c;

  always_comb begin
    b_eff = b_i ^ {DATA_W{sub_i}};
    g     = a_i & b_eff;
    p     = a_i ^ b_eff;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = &p[4*k +: 4];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    // Group carries come from the second lookahead level; subtract injects cin = 1.
    c     = '0;
    c[0]  = sub_i;
    c[4]  = grp_g[0] | (grp_p[0] & c[0]);
    c[8]  = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c[0]);
    c[12] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[2] & grp_p[1] & grp_p[0] & c[0]);
    c[16] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
          | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c[0]);
    for (int k = 0; k < 4; k++) begin
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
    raw    = p ^ c[DATA_W-1:0];
    ovfl_o = c[DATA_W] ^ c[DATA_W-1];
    // On overflow both effective operands share a sign, so a's sign gives the direction.
    if (ovfl_o) begin
      sum_o = a_i[DATA_W-1] ? SAT_NEG : SAT_POS;
    end else begin
      sum_o = raw;
    end
  end

endmodule

// File: rtl/addsub_ex_stage.sv
// Two-stage pipelined saturating add/subtract with flags and saturation counter.
module addsub_ex_stage
  import addsub_ex_stage_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_sub,
  input  logic              in_upd_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovfl,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic [CNT_W-1:0]  sat_count
);

  s1_payload_t       s1_q, s1_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              ovfl_q, ovfl_d;
  logic              z_q, z_d, v_q, v_d, n_q, n_d;
  logic [CNT_W-1:0]  sat_q, sat_d;

  logic              s2_adv;
  logic              s1_move;
  logic [DATA_W-1:0] cla_sum;
  logic              cla_ovfl;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign s1_move  = s1_valid_q && s2_adv;

  cla_16bit u_cla (
    .a_i    (s1_q.a),
    .b_i    (s1_q.b),
    .sub_i  (s1_q.sub),
    .sum_o  (cla_sum),
    .ovfl_o (cla_ovfl)
  );

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    ovfl_d     = ovfl_q;
    z_d        = z_q;
    v_d        = v_q;
    n_d        = n_q;
    sat_d      = sat_q;

    if (in_valid && in_ready) begin
      s1_d.a         = in_a;
      s1_d.b         = in_b;
      s1_d.sub       = in_sub;
      s1_d.upd_flags = in_upd_flags;
      s1_valid_d     = 1'b1;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end

    // Results, flags and counter only see packets that actually enter S2.
    if (s1_move) begin
      sum_d  = cla_sum;
      ovfl_d = cla_ovfl;
      if (s1_q.upd_flags) begin
        z_d = (cla_sum == '0);
        v_d = cla_ovfl;
        n_d = cla_sum[DATA_W-1];
      end
      if (cla_ovfl && (sat_q != {CNT_W{1'b1}})) begin
        sat_d = sat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      ovfl_q     <= 1'b0;
      z_q        <= 1'b0;
      v_q        <= 1'b0;
      n_q        <= 1'b0;
      sat_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      ovfl_q     <= ovfl_d;
      z_q        <= z_d;
      v_q        <= v_d;
      n_q        <= n_d;
      sat_q      <= sat_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = sum_q;
  assign out_ovfl  = ovfl_q;
  assign flag_z    = z_q;
  assign flag_v    = v_q;
  assign flag_n    = n_q;
  assign sat_count = sat_q;

endmodule

// File: tb/tb_addsub_ex_stage.sv
// Scoreboard bench for addsub_ex_stage: reference model at acceptance, monitor at output.
module tb_addsub_ex_stage;

  localparam int CNT_W   = 8;
  localparam int SAT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [15:0] sum;
    logic        ovfl;
    logic        z, v, n;
    int          sat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_a = '0;
  logic [15:0]       in_b = '0;
  logic              in_sub = 1'b0;
  logic              in_upd_flags = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [15:0]       out_sum;
  logic              out_ovfl;
  logic              flag_z, flag_v, flag_n;
  logic [CNT_W-1:0]  sat_count;

  addsub_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sub       (in_sub),
    .in_upd_flags (in_upd_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_ovfl     (out_ovfl),
    .flag_z       (flag_z),
    .flag_v       (flag_v),
    .flag_n       (flag_n),
    .sat_count    (sat_count)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  exp_t sb_q[$];

  // Architectural model state, advanced in acceptance order.
  logic m_z = 1'b0, m_v = 1'b0, m_n = 1'b0;
  int   m_sat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic u);
    exp_t e;
    int   exact;
    exact = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    if (exact > 32767) begin
      e.sum = 16'h7FFF; e.ovfl = 1'b1;
    end else if (exact < -32768) begin
      e.sum = 16'h8000; e.ovfl = 1'b1;
    end else begin
      e.sum = 16'(exact); e.ovfl = 1'b0;
    end
    if (u) begin
      m_z = (e.sum == 16'h0000);
      m_v = e.ovfl;
      m_n = e.sum[15];
    end
    if (e.ovfl && m_sat < SAT_MAX) m_sat++;
    e.z = m_z; e.v = m_v; e.n = m_n; e.sat = m_sat;
    return e;
  endfunction

  // Input side: every accepted packet pushes its expected result.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      sb_q.push_back(model(in_a, in_b, in_sub, in_upd_flags));
    end
  end

  // Output side: compare on each output transfer; also check stall stability.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_sum;
  logic        prev_ovfl;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_sum",   32'(out_sum),   32'(prev_sum));
        check("stall_ovfl",  32'(out_ovfl),  32'(prev_ovfl));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'(out_sum), 32'hDEAD_BEEF);
        end else begin
          e = sb_q.pop_front();
          n_out++;
          check("sum",       32'(out_sum),   32'(e.sum));
          check("ovfl",      32'(out_ovfl),  32'(e.ovfl));
          check("flag_z",    32'(flag_z),    32'(e.z));
          check("flag_v",    32'(flag_v),    32'(e.v));
          check("flag_n",    32'(flag_n),    32'(e.n));
          check("sat_count", 32'(sat_count), 32'(e.sat));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_ovfl  = out_ovfl;
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb_q.delete();
    m_z = 1'b0; m_v = 1'b0; m_n = 1'b0; m_sat = 0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic u);
    int   g;
    logic acc;
    g = 0;
    in_a = a; in_b = b; in_sub = s; in_upd_flags = u; in_valid = 1'b1;
    do begin
      @(negedge clk); acc = in_ready;
      cycle(); g++;
    end while (!acc && g < 64);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && g < 200) begin
      cycle(); g++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'(($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0001);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int acc, base, g;

    cycle(); cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_flags",     32'({flag_z, flag_v, flag_n}), 32'd0);
    check("rst_sat",       32'(sat_count), 32'd0);
    cycle();

    // Positive saturation with two-cycle latency.
    out_ready = 1'b1;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    cycle();
    check("lat_valid",  32'(out_valid), 32'd1);
    check("pos_sat",    32'(out_sum),   32'h7FFF);
    check("pos_ovfl",   32'(out_ovfl),  32'd1);
    check("pos_flags",  32'({flag_z, flag_v, flag_n}), 32'b010);
    check("pos_satcnt", 32'(sat_count), 32'd1);
    drain();

    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    cycle();
    check("neg_sat",   32'(out_sum),  32'h8000);
    check("neg_flags", 32'({flag_v, flag_n}), 32'b11);
    drain();

    send(16'h1234, 16'h1234, 1'b1, 1'b1);
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    drain();
    check("noupd_sum",   32'(out_sum), 32'h0002);
    check("noupd_flags", 32'({flag_z, flag_v}), 32'b10);

    // Backpressure: four packets, output held off for three cycles.
    out_ready = 1'b0;
    acc = 0;
    base = n_out;
    in_valid = 1'b1; in_a = 16'h0010; in_b = 16'h0001; in_sub = 1'b0; in_upd_flags = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready) acc++;
      cycle();
      in_a = 16'h0010 + 16'(acc);
    end
    in_valid = 1'b0;
    check("stall_accepts",  32'(acc), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = acc; i < 4; i++) send(16'h0010 + 16'(i), 16'h0001, 1'b0, 1'b1);
    drain();
    check("stall_out_count", 32'(n_out - base), 32'd4);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_a         = rand_op();
      in_b         = rand_op();
      in_sub       = 1'($urandom_range(0, 1));
      in_upd_flags = 1'($urandom_range(0, 1));
      out_ready    = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid = 1'b0;
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
    send(16'h4000, 16'h4000, 1'b0, 1'b1);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    cycle();
    do_reset();
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_flags",     32'({flag_z, flag_v, flag_n}), 32'd0);
    check("mid_rst_sat",       32'(sat_count), 32'd0);
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 4; i++) cycle();
    check("no_stale_output", 32'(n_out - base), 32'd0);

    // Counter saturation.
    acc = 0; g = 0;
    in_valid = 1'b1; in_a = 16'h7FFF; in_b = 16'h7FFF; in_sub = 1'b0; in_upd_flags = 1'b0;
    while (acc < 300 && g < 1000) begin
      @(negedge clk);
      if (in_ready) acc++;
      cycle(); g++;
    end
    in_valid = 1'b0;
    check("ovf_accepts", 32'(acc), 32'd300);
    drain();
    check("sat_count_max", 32'(sat_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
